vga_pattern_gen: RTL and testbench
==================================

# vga_pattern_gen

Parametrised scrolling test-pattern generator between the VGA timing generator and the DAC/pin outputs. It consumes the timing block's pixel counters and active flag, and produces registered RGB with one cycle of latency. It supports four pattern modes, a configurable bar count and width, and run-time scroll step, rate, direction and pause. All mode and scroll controls change only at frame boundaries, so a frame never tears.

## Interface
- `COLOR_W`, 4: bits per colour channel.
- `H_W`, 10: hcount width; also the scroll offset width.
- `V_W`, 10: vcount width; must be ≤ `H_W`.
- `BAR_SHIFT`, 8: bar/tile size is 2^`BAR_SHIFT` pixels; must be ≥ `COLOR_W`.
- `NUM_BARS`, 4: palette entries cycled; power of 2, 2..8.
- `DIV_W`, 6: width of the frame divider.
- `clk` in 1: pixel clock.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `hcount_in` in `H_W`: pixel column.
- `vcount_in` in `V_W`: pixel row.
- `active_in` in 1: visible-area flag.
- `mode_in` in 2: 0 vertical bars, 1 horizontal bars, 2 checkerboard, 3 gradient.
- `step_in` in `H_W`: pixels added per scroll step.
- `div_in` in `DIV_W`: frames per step, minus 1.
- `dir_in` in 1: 0 adds to offset, 1 subtracts.
- `pause_in` in 1: freezes scrolling.
- `r_out`, `g_out`, `b_out` out `COLOR_W`: colour.
- `active_out` in 1 → out 1: `active_in` delayed 1 cycle.
- `frame_tick_out` out 1: one-cycle pulse aligned with pixel (0,0) output.

## Operation
- **Frame start (FS):** the cycle with `hcount_in`==0 and `vcount_in`==0.
- **Shadow registers:** `mode_q`, `step_q`, `dir_q` and `pause_q` load from their inputs only at FS.
- **Frame counter `fcnt`:** updates only at FS, using the shadow values being loaded in that cycle.
  - If paused: `fcnt` and `offset` hold.
  - Else if `fcnt` ≥ `div_in`: `offset` ← `offset` ± `step_in` (mod 2^`H_W`) and `fcnt` ← 0.
  - Else: `fcnt` ← `fcnt` + 1.
- **FS bypass:** the FS pixel itself is coloured with the post-update mode and offset, i.e. the combinational next values. Every pixel of a frame therefore uses one consistent configuration.
- **Scrolled coordinates:** `sx` = (`hcount` + `offset`) mod 2^`H_W`; `sy` = (`vcount` + `offset`[`V_W`-1:0]) mod 2^`V_W`.
- **Palette** (index → RGB, full scale = all ones): 0 red, 1 green, 2 blue, 3 white, 4 yellow, 5 cyan, 6 magenta, 7 black.
- **Modes:**
  - VBARS: index = (`sx` >> `BAR_SHIFT`) mod `NUM_BARS`.
  - HBARS: index = (`sy` >> `BAR_SHIFT`) mod `NUM_BARS`.
  - CHECKER: bit (`sx` >> `BAR_SHIFT`)[0] XOR (`vcount` >> `BAR_SHIFT`)[0]; 1 gives white, 0 gives black.
  - GRADIENT: all channels = `sx`[`BAR_SHIFT`-1 -: `COLOR_W`].
- **Blanking:** when `active_in`=0, the registered RGB is 0.

## Timing
- Latency 1 cycle, input to `*_out`, for RGB, `active_out` and `frame_tick_out`. Throughput is one pixel per clock.
- **Reset:** the edge with `rst`=1 sets every output to 0, and `offset`, `fcnt` and all shadow registers to 0 (mode = VBARS).
- **Reset mid-frame:** output stays 0 while `rst` is held. The first output after release reflects inputs from the release cycle, using reset configuration until the next FS.
- **Reset and FS in the same cycle:** reset wins; there is no step.
- **First step after reset:** with `div_in`=D held, the first step occurs at FS number D+1. D=0 steps every frame.
- **Wrap-around:** `offset` is modular both up and down; no saturation.
- **Between FS:** changing `mode_in`, `step_in`, `dir_in`, `pause_in` or `div_in` has no visible effect until the next FS.

## Structure
- Package `vga_pattern_pkg` holds:
  - `pattern_mode_t` enum: `PAT_VBARS`, `PAT_HBARS`, `PAT_CHECKER`, `PAT_GRADIENT`.
  - An 8-entry palette constant of 3-bit RGB enables.
  - `palette_rgb()` function expanding an enable triple to `COLOR_W` channels.
- Sub-module `vga_scroll_ctrl` holds the FS detect, shadow registers, `fcnt` and `offset`. It outputs `offset_eff`, `mode_eff` (FS-bypassed) and `fs`. The top level holds the coordinate math, palette lookup and output register.

## Test plan
Defaults apply throughout: `COLOR_W`=4, `H_W`=`V_W`=10, `BAR_SHIFT`=8, `NUM_BARS`=4.
- **Reset bars:** reset, then mode 0 with `active_in`=1. Column 0 → F/0/0, 256 → 0/F/0, 512 → 0/0/F, 768 → F/F/F, each one cycle later. `active_in`=0 → 0/0/0.
- **Scroll rate:** `step_in`=10, `div_in`=63. Offset stays 0 through 63 FS and becomes 10 at FS 64. On that frame, column 246 → green and column 245 → red. With `div_in`=0, offset is 20 after 2 FS.
- **Reverse wrap:** `dir_in`=1, `step_in`=10, `div_in`=0. After 1 FS, offset = 1014; column 10 → red, column 9 → white.
- **Frame-locked mode change:** at (h=100, v=50), `mode_in` changes 0→2. Remaining pixels of that frame stay bars. Pixel (0,0) of the next frame is black, (0,256) is white, and `frame_tick_out`=1 on that same output cycle.
- **Gradient and pause:** mode 3, offset 0. Column 0x1F0 → F/F/F and 0x100 → 0/0/0. Assert `pause_in` before FS: offset unchanged over 5 frames; deassert and the offset resumes stepping per `fcnt`.
- **Mid-frame reset:** assert `rst` for 3 cycles mid-frame. RGB, `active_out` and `frame_tick_out` are 0 the cycle after each reset edge, and offset is 0 afterwards.

Source files
------------

// File: rtl/vga_pattern_pkg.sv
// Shared types and palette for the scrolling VGA test-pattern generator.
package vga_pattern_pkg;

  typedef enum logic [1:0] {
    PAT_VBARS    = 2'd0,
    PAT_HBARS    = 2'd1,
    PAT_CHECKER  = 2'd2,
    PAT_GRADIENT = 2'd3
  } pattern_mode_t;

  localparam int MAX_COLOR_W = 8;

  typedef struct packed {
    logic [MAX_COLOR_W-1:0] r;
    logic [MAX_COLOR_W-1:0] g;
    logic [MAX_COLOR_W-1:0] b;
  } color_t;

  // {r,g,b} enables; index 0 is the rightmost entry.
  localparam logic [7:0][2:0] PALETTE = {
    3'b000, 3'b101, 3'b011, 3'b110, 3'b111, 3'b001, 3'b010, 3'b100
  };

  // Callers truncate to their channel width; every bit of a lit channel is one.
  function automatic color_t palette_rgb(input logic [2:0] en);
    color_t c;
    c.r = {MAX_COLOR_W{en[2]}};
    c.g = {MAX_COLOR_W{en[1]}};
    c.b = {MAX_COLOR_W{en[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_scroll_ctrl.sv
// Frame-locked shadow configuration, frame divider and scroll offset.
module vga_scroll_ctrl
  import vga_pattern_pkg::*;
#(
  parameter int H_W   = 10,
  parameter int V_W   = 10,
  parameter int DIV_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [H_W-1:0] hcount,
  input  logic [V_W-1:0] vcount,
  input  logic [1:0]     mode,
  input  logic [H_W-1:0] step,
  input  logic [DIV_W-1:0] div,
  input  logic           dir,
  input  logic           pause,
  output logic [H_W-1:0] offset_eff,
  output pattern_mode_t  mode_eff,
  output logic           fs
);

  pattern_mode_t     mode_q, mode_nxt;
  logic [H_W-1:0]    step_q, step_nxt;
  logic              dir_q, dir_nxt;
  logic              pause_q, pause_nxt;
  logic [DIV_W-1:0]  fcnt, fcnt_nxt;
  logic [H_W-1:0]    offset, offset_nxt;

  assign fs = (hcount == '0) && (vcount == '0);

  // Next values double as the FS bypass so the first pixel matches the rest of its frame.
  always_comb begin
    mode_nxt   = fs ? pattern_mode_t'(mode) : mode_q;
    step_nxt   = fs ? step  : step_q;
    dir_nxt    = fs ? dir   : dir_q;
    pause_nxt  = fs ? pause : pause_q;
    fcnt_nxt   = fcnt;
    offset_nxt = offset;
    if (fs && !pause_nxt) begin
      if (fcnt >= div) begin
        offset_nxt = dir_nxt ? offset - step_nxt : offset + step_nxt;
        fcnt_nxt   = '0;
      end else begin
        fcnt_nxt = fcnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= PAT_VBARS;
      step_q  <= '0;
      dir_q   <= 1'b0;
      pause_q <= 1'b0;
      fcnt    <= '0;
      offset  <= '0;
    end else begin
      mode_q  <= mode_nxt;
      step_q  <= step_nxt;
      dir_q   <= dir_nxt;
      pause_q <= pause_nxt;
      fcnt    <= fcnt_nxt;
      offset  <= offset_nxt;
    end
  end

  assign offset_eff = offset_nxt;
  assign mode_eff   = mode_nxt;

endmodule

// File: rtl/vga_pattern_gen.sv
// Scrolling bar/checker/gradient pattern generator with one registered output stage.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int COLOR_W   = 4,
  parameter int H_W       = 10,
  parameter int V_W       = 10,
  parameter int BAR_SHIFT = 8,
  parameter int NUM_BARS  = 4,
  parameter int DIV_W     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [H_W-1:0]     hcount_in,
  input  logic [V_W-1:0]     vcount_in,
  input  logic               active_in,
  input  logic [1:0]         mode_in,
  input  logic [H_W-1:0]     step_in,
  input  logic [DIV_W-1:0]   div_in,
  input  logic               dir_in,
  input  logic               pause_in,
  output logic [COLOR_W-1:0] r_out,
  output logic [COLOR_W-1:0] g_out,
  output logic [COLOR_W-1:0] b_out,
  output logic               active_out,
  output logic               frame_tick_out
);

  logic [H_W-1:0] offset_eff;
  pattern_mode_t  mode_eff;
  logic           fs;

  vga_scroll_ctrl #(
    .H_W   (H_W),
    .V_W   (V_W),
    .DIV_W (DIV_W)
  ) u_scroll (
    .clk        (clk),
    .rst        (rst),
    .hcount     (hcount_in),
    .vcount     (vcount_in),
    .mode       (mode_in),
    .step       (step_in),
    .div        (div_in),
    .dir        (dir_in),
    .pause      (pause_in),
    .offset_eff (offset_eff),
    .mode_eff   (mode_eff),
    .fs         (fs)
  );

  logic [H_W-1:0]     sx;
  logic [V_W-1:0]     sy;
  logic               chk;
  logic [2:0]         pal_idx;
  color_t             pal;
  logic [COLOR_W-1:0] r_p0, g_p0, b_p0;

  assign sx  = hcount_in + offset_eff;
  assign sy  = vcount_in + offset_eff[V_W-1:0];
  // Checker rows follow the unscrolled line number; only columns scroll.
  assign chk = ((sx >> BAR_SHIFT) & H_W'(1)) != ((H_W'(vcount_in) >> BAR_SHIFT) & H_W'(1));

  always_comb begin
    pal_idx = 3'd7;
    case (mode_eff)
      PAT_VBARS:   pal_idx = 3'((sx >> BAR_SHIFT) & H_W'(NUM_BARS - 1));
      PAT_HBARS:   pal_idx = 3'((sy >> BAR_SHIFT) & V_W'(NUM_BARS - 1));
      PAT_CHECKER: pal_idx = chk ? 3'd3 : 3'd7;
      default:     pal_idx = 3'd7;
    endcase
    pal = palette_rgb(PALETTE[pal_idx]);
    if (mode_eff == PAT_GRADIENT) begin
      r_p0 = sx[BAR_SHIFT-1 -: COLOR_W];
      g_p0 = sx[BAR_SHIFT-1 -: COLOR_W];
      b_p0 = sx[BAR_SHIFT-1 -: COLOR_W];
    end else begin
      r_p0 = COLOR_W'(pal.r);
      g_p0 = COLOR_W'(pal.g);
      b_p0 = COLOR_W'(pal.b);
    end
    if (!active_in) begin
      r_p0 = '0;
      g_p0 = '0;
      b_p0 = '0;
    end
  end

  // p0 -> p1: output register
  logic [COLOR_W-1:0] r_p1, g_p1, b_p1;
  logic               vld_p1, tick_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1    <= '0;
      g_p1    <= '0;
      b_p1    <= '0;
      vld_p1  <= 1'b0;
      tick_p1 <= 1'b0;
    end else begin
      r_p1    <= r_p0;
      g_p1    <= g_p0;
      b_p1    <= b_p0;
      vld_p1  <= active_in;
      tick_p1 <= fs;
    end
  end

  assign r_out          = r_p1;
  assign g_out          = g_p1;
  assign b_out          = b_p1;
  assign active_out     = vld_p1;
  assign frame_tick_out = tick_p1;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed and randomized checks of vga_pattern_gen against a frame-level reference model.
module tb_vga_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hcount_in, vcount_in;
  logic       active_in;
  logic [1:0] mode_in;
  logic [9:0] step_in;
  logic [5:0] div_in;
  logic       dir_in, pause_in;
  logic [3:0] r_out, g_out, b_out;
  logic       active_out, frame_tick_out;

  vga_pattern_gen dut (
    .clk            (clk),
    .rst            (rst),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .active_in      (active_in),
    .mode_in        (mode_in),
    .step_in        (step_in),
    .div_in         (div_in),
    .dir_in         (dir_in),
    .pause_in       (pause_in),
    .r_out          (r_out),
    .g_out          (g_out),
    .b_out          (b_out),
    .active_out     (active_out),
    .frame_tick_out (frame_tick_out)
  );

  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  string sect  = "init";

  // Reference state: the scroll position and configuration in force for the current frame.
  int m_off  = 0;
  int m_fcnt = 0;
  int m_mode = 0;

  logic [11:0] pal_hex [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF,
                               12'hFF0, 12'h0FF, 12'hF0F, 12'h000};

  function automatic logic [11:0] ref_pixel(input int h, input int v, input int mode, input int off);
    int sx, sy, lvl;
    logic [3:0] l4;
    sx = (h + off) % 1024;
    sy = (v + off) % 1024;
    case (mode)
      0: return pal_hex[(sx / 256) % 4];
      1: return pal_hex[(sy / 256) % 4];
      2: return (((sx / 256) + (v / 256)) % 2 == 1) ? 12'hFFF : 12'h000;
      default: begin
        lvl = (sx % 256) / 16;
        l4  = 4'(lvl);
        return {l4, l4, l4};
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s %s: got %h expected %h", sect, tag, got, exp);
    end
  endtask

  task automatic pix(input int h, input int v, input bit a);
    logic [11:0] e_rgb;
    bit          e_act, e_tick;
    if (rst) begin
      m_off = 0; m_fcnt = 0; m_mode = 0;
      e_rgb = 12'h000; e_act = 1'b0; e_tick = 1'b0;
    end else begin
      e_tick = (h == 0) && (v == 0);
      if (e_tick) begin
        m_mode = int'(mode_in);
        if (!pause_in) begin
          if (m_fcnt >= int'(div_in)) begin
            m_off  = dir_in ? (m_off + 1024 - int'(step_in)) % 1024
                            : (m_off + int'(step_in)) % 1024;
            m_fcnt = 0;
          end else begin
            m_fcnt++;
          end
        end
      end
      e_rgb = a ? ref_pixel(h, v, m_mode, m_off) : 12'h000;
      e_act = a;
    end
    hcount_in = 10'(h);
    vcount_in = 10'(v);
    active_in = a;
    @(posedge clk);
    #1;
    check("rgb",  {r_out, g_out, b_out}, e_rgb);
    check("act",  {11'd0, active_out}, {11'd0, e_act});
    check("tick", {11'd0, frame_tick_out}, {11'd0, e_tick});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pix(0, 0, 1'b1);
    pix(37, 5, 1'b1);
    rst = 1'b0;
  endtask

  task automatic cfg(input int mode, input int stp, input int dv, input bit dr, input bit ps);
    mode_in  = 2'(mode);
    step_in  = 10'(stp);
    div_in   = 6'(dv);
    dir_in   = dr;
    pause_in = ps;
  endtask

  initial begin
    rst = 1'b1;
    hcount_in = 10'd0; vcount_in = 10'd0; active_in = 1'b0;
    cfg(0, 0, 0, 1'b0, 1'b0);

    sect = "reset";
    pix(0, 0, 1'b1);
    pix(5, 5, 1'b1);
    rst = 1'b0;

    sect = "bars";
    pix(0, 5, 1'b1);
    pix(256, 5, 1'b1);
    pix(512, 5, 1'b1);
    pix(768, 5, 1'b1);
    pix(300, 5, 1'b0);

    sect = "rate63";
    do_reset();
    cfg(0, 10, 63, 1'b0, 1'b0);
    for (int k = 1; k <= 64; k++) begin
      pix(0, 0, 1'b1);
      pix(255, 7, 1'b1);
      pix(246, 7, 1'b1);
      pix(245, 7, 1'b1);
    end

    sect = "rate0";
    do_reset();
    cfg(0, 10, 0, 1'b0, 1'b0);
    pix(0, 0, 1'b1);
    pix(0, 0, 1'b1);
    pix(236, 3, 1'b1);
    pix(235, 3, 1'b1);

    sect = "reverse";
    do_reset();
    cfg(0, 10, 0, 1'b1, 1'b0);
    pix(0, 0, 1'b1);
    pix(10, 3, 1'b1);
    pix(9, 3, 1'b1);

    sect = "modechg";
    do_reset();
    cfg(0, 0, 0, 1'b0, 1'b0);
    pix(0, 0, 1'b1);
    mode_in = 2'd2;
    pix(100, 50, 1'b1);
    pix(300, 50, 1'b1);
    pix(600, 900, 1'b1);
    pix(0, 0, 1'b1);
    pix(0, 256, 1'b1);

    sect = "gradient";
    do_reset();
    cfg(3, 0, 0, 1'b0, 1'b0);
    pix(0, 0, 1'b1);
    pix(10'h1F0, 4, 1'b1);
    pix(10'h100, 4, 1'b1);
    cfg(3, 16, 0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      pix(0, 0, 1'b1);
      pix(10'h1F0, 4, 1'b1);
    end
    pause_in = 1'b0;
    pix(0, 0, 1'b1);
    pix(10'h1F0, 4, 1'b1);
    pix(10'h1E0, 4, 1'b1);

    sect = "midrst";
    do_reset();
    cfg(0, 100, 0, 1'b0, 1'b0);
    pix(0, 0, 1'b1);
    pix(10, 20, 1'b1);
    rst = 1'b1;
    pix(11, 20, 1'b1);
    pix(0, 0, 1'b1);
    pix(13, 20, 1'b1);
    rst = 1'b0;
    mode_in = 2'd2;
    pix(300, 20, 1'b1);
    pix(255, 20, 1'b1);
    pix(0, 0, 1'b1);
    pix(300, 20, 1'b1);

    sect = "random";
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit is_fs;
      cfg($urandom_range(0, 3), $urandom_range(0, 1023), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      rst   = ($urandom_range(0, 63) == 0);
      is_fs = ($urandom_range(0, 5) == 0);
      if (is_fs) pix(0, 0, 1'($urandom_range(0, 1)));
      else pix($urandom_range(1, 1023), $urandom_range(0, 1023), ($urandom_range(0, 4) != 0));
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
